// File: rtl/apb_timer_slave.sv
// apb_timer_slave: zero-wait-state APB down-counting timer with prescaler, auto-reload and irq.
// Define TIMER_PWM_EN to build the COMPARE register and the registered pwm_out compare output.
module apb_timer_slave #(
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 8
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq,
  output logic        pwm_out
);

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_LOAD    = 3'd1;
  localparam logic [2:0] ADDR_COUNT   = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_COMPARE = 3'd4;

  logic                 en, auto_rl, irq_en, exp_flag;
  logic [PRE_WIDTH-1:0] prescale, pre_cnt;
  logic [CNT_WIDTH-1:0] load_val, count;
  logic                 wr_en, rd_setup, tick, expire;
  logic [2:0]           addr;
  logic [31:0]          rd_mux;
  logic                 unused_ok;

  assign addr      = paddr[4:2];
  assign wr_en     = psel & penable & pwrite;
  assign rd_setup  = psel & ~penable & ~pwrite;
  assign tick      = en & (pre_cnt == prescale);
  assign expire    = tick & (count == '0);
  assign irq       = exp_flag & irq_en;
  assign unused_ok = ^{paddr[31:5], paddr[1:0], pwdata};

`ifdef TIMER_PWM_EN
  logic [CNT_WIDTH-1:0] compare;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      compare <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_en && addr == ADDR_COMPARE) compare <= pwdata[CNT_WIDTH-1:0];
      pwm_out <= en & (count < compare);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_mux[0]              = en;
        rd_mux[1]              = auto_rl;
        rd_mux[2]              = irq_en;
        rd_mux[8 +: PRE_WIDTH] = prescale;
      end
      ADDR_LOAD:    rd_mux    = 32'(load_val);
      ADDR_COUNT:   rd_mux    = 32'(count);
      ADDR_STATUS:  rd_mux[0] = exp_flag;
`ifdef TIMER_PWM_EN
      ADDR_COMPARE: rd_mux    = 32'(compare);
`endif
      default:      rd_mux    = '0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      load_val <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      prdata   <= '0;
    end else begin
      // prdata captured in setup so it is stable for the whole access phase
      if (rd_setup) prdata <= rd_mux;

      if (!en || tick) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + 1'b1;

      if (tick) begin
        if (count != '0) count <= count - 1'b1;
        else if (auto_rl) count <= load_val;
      end

      if (wr_en && addr == ADDR_LOAD) begin
        load_val <= pwdata[CNT_WIDTH-1:0];
        if (!en) count <= pwdata[CNT_WIDTH-1:0];
      end

      // a new expiry outranks a simultaneous W1C
      if (expire)                                           exp_flag <= 1'b1;
      else if (wr_en && addr == ADDR_STATUS && pwdata[0])   exp_flag <= 1'b0;

      if (wr_en && addr == ADDR_CTRL) begin
        en       <= pwdata[0];
        auto_rl  <= pwdata[1];
        irq_en   <= pwdata[2];
        prescale <= pwdata[8 +: PRE_WIDTH];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: random and directed APB traffic checked against a cycle reference
// model through a scoreboard queue drained by a monitor on the falling clock edge.
module tb_apb_timer_slave;

  logic        hclk = 1'b0;
  logic        hreset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        irq, pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TIMER_PWM_EN
  localparam bit PWM_BUILD = 1'b1;
`else
  localparam bit PWM_BUILD = 1'b0;
`endif

  apb_timer_slave dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  always #5 hclk = ~hclk;

  // reference model state
  bit        m_en, m_auto, m_ie, m_exp, m_pwm;
  bit [7:0]  m_ps, m_pre;
  bit [31:0] m_load, m_cnt, m_cmp, m_prdata;

  typedef struct {
    bit        irq;
    bit        pwm;
    bit [31:0] prdata;
    bit        rd;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input int idx);
    case (idx)
      0:       return {16'd0, m_ps, 5'd0, m_ie, m_auto, m_en};
      1:       return m_load;
      2:       return m_cnt;
      3:       return {31'd0, m_exp};
      4:       return PWM_BUILD ? m_cmp : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge hclk) begin
    exp_t e;
    bit   wr, rd, ticked, rolled, en_before, new_pwm;
    int   idx;
    rd = 1'b0;
    if (hreset) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_pwm = 0;
      m_ps = 0; m_pre = 0; m_load = 0; m_cnt = 0; m_cmp = 0; m_prdata = 0;
    end else begin
      wr  = psel && penable && pwrite;
      rd  = psel && !penable && !pwrite;
      idx = int'(paddr[4:2]);
      if (rd) m_prdata = model_read(idx);
      new_pwm   = PWM_BUILD && m_en && (m_cnt < m_cmp);
      en_before = m_en;
      ticked    = m_en && (m_pre == m_ps);
      rolled    = ticked && (m_cnt == 0);
      m_pre     = (!m_en || ticked) ? 8'd0 : m_pre + 8'd1;
      if (ticked) m_cnt = (m_cnt != 0) ? m_cnt - 1 : (m_auto ? m_load : 32'd0);
      if (rolled && !m_auto) m_en = 0;
      if (wr) begin
        case (idx)
          0: begin m_en = pwdata[0]; m_auto = pwdata[1]; m_ie = pwdata[2]; m_ps = pwdata[15:8]; end
          1: begin m_load = pwdata; if (!en_before) m_cnt = pwdata; end
          3: if (pwdata[0]) m_exp = 0;
          4: if (PWM_BUILD) m_cmp = pwdata;
          default: ;
        endcase
      end
      if (rolled) m_exp = 1;
      m_pwm = new_pwm;
    end
    e.irq    = m_exp && m_ie;
    e.pwm    = m_pwm;
    e.prdata = m_prdata;
    e.rd     = rd;
    sb_q.push_back(e);
  end

  always @(negedge hclk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(e.rd ? "read_prdata" : "prdata_hold", prdata, e.prdata);
      check("irq", {31'd0, irq}, {31'd0, e.irq});
      check("pwm_out", {31'd0, pwm_out}, {31'd0, e.pwm});
    end
  end

  function automatic logic [31:0] rnd_addr(input int idx);
    logic [31:0] noise;
    noise = $urandom;
    return (noise & 32'hFFFF_FFE3) | (32'(idx) << 2);
  endfunction

  // all bus tasks start and end on a falling edge
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge hclk); penable = 1;
    @(negedge hclk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [31:0] a);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge hclk); penable = 1;
    @(negedge hclk); psel = 0; penable = 0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(negedge hclk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, r, idx;
    logic [31:0] d;
    hreset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    @(negedge hclk); @(negedge hclk);
    hreset = 0;
    for (int i = 0; i < 4; i++) apb_read(rnd_addr(i));

    // one-shot, prescale 0
    apb_write(rnd_addr(1), 32'd3);
    apb_write(rnd_addr(0), 32'h5);
    wait_irq(n);
    check("oneshot_latency", n, 4);
    apb_read(rnd_addr(2));
    apb_read(rnd_addr(0));

    // auto-reload with prescale 2
    apb_write(rnd_addr(3), 32'h1);
    apb_write(rnd_addr(1), 32'd2);
    apb_write(rnd_addr(0), 32'h0207);
    wait_irq(n);
    check("prescale_first_expiry", n, 9);
    apb_write(rnd_addr(3), 32'h1);
    check("w1c_irq_clear", {31'd0, irq}, 32'd0);
    wait_irq(n);
    check("auto_period", n, 7);
    apb_read(rnd_addr(2));

    // W1C landing on the same edge as an expiry
    apb_write(rnd_addr(0), 32'h0);
    apb_write(rnd_addr(3), 32'h1);
    apb_write(rnd_addr(1), 32'd3);
    apb_write(rnd_addr(0), 32'h7);
    wait_irq(n);
    check("auto_first_expiry", n, 4);
    apb_write(rnd_addr(3), 32'h1);
    check("w1c_before_collision", {31'd0, irq}, 32'd0);
    apb_write(rnd_addr(3), 32'h1);
    check("set_beats_w1c", {31'd0, irq}, 32'd1);
    apb_read(rnd_addr(3));

    // LOAD rewrite while running
    apb_write(rnd_addr(0), 32'h0);
    apb_write(rnd_addr(3), 32'h1);
    apb_write(rnd_addr(1), 32'd2);
    apb_write(rnd_addr(0), 32'h3);
    apb_write(rnd_addr(1), 32'd7);
    repeat (12) apb_read(rnd_addr(2));

    // unmapped / read-only writes
    apb_write(rnd_addr(0), 32'h0);
    apb_write(32'h08, 32'hFFFF_FFFF);
    apb_write(32'h14, 32'hFFFF_FFFF);
    apb_write(32'h1C, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) apb_read(rnd_addr(i));

    // compare output duty
    apb_write(rnd_addr(1), 32'd9);
    apb_write(rnd_addr(4), 32'd4);
    apb_write(rnd_addr(0), 32'h3);
    repeat (10) @(negedge hclk);
    hi = 0;
    repeat (20) begin
      @(negedge hclk);
      if (pwm_out === 1'b1) hi++;
    end
    check("pwm_duty", hi, PWM_BUILD ? 8 : 0);

    // reset during the access phase of a write
    apb_write(rnd_addr(0), 32'h7);
    psel = 1; penable = 0; pwrite = 1; paddr = rnd_addr(1); pwdata = 32'd5;
    @(negedge hclk); penable = 1; hreset = 1;
    @(negedge hclk); hreset = 0; psel = 0; penable = 0; pwrite = 0;
    check("reset_mid_access_irq", {31'd0, irq}, 32'd0);
    apb_read(rnd_addr(0));
    apb_read(rnd_addr(1));

    // randomized traffic
    repeat (300) begin
      r = $urandom_range(0, 19);
      if (r < 4) begin
        repeat ($urandom_range(1, 4)) @(negedge hclk);
      end else if (r < 11) begin
        idx = $urandom_range(0, 7);
        d   = $urandom;
        case (idx)
          0: d[15:8] = 8'($urandom_range(0, 3));
          1: if ($urandom_range(0, 7) != 0) d = $urandom_range(0, 10);
          4: d = $urandom_range(0, 10);
          default: ;
        endcase
        apb_write(rnd_addr(idx), d);
      end else if (r < 19) begin
        apb_read(rnd_addr($urandom_range(0, 7)));
      end else begin
        hreset = 1;
        @(negedge hclk);
        hreset = 0;
      end
    end

    repeat (3) @(negedge hclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
